// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - FSM that sequences an external shifter through load and 1/8-bit steps
module shift_sequencer #(
    parameter bit COARSE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_data,
    input  logic        req_dir,
    input  logic [5:0]  req_count,
    output logic        sh_load,
    output logic        sh_ena,
    output logic [1:0]  sh_amount,
    output logic [63:0] sh_data,
    input  logic [63:0] sh_q,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [5:0] remaining;
    logic       dir_q;
    logic [1:0] amount_q;
    logic       coarse_step;
    logic [1:0] step_code;
    logic [5:0] remaining_next;

    // Coarse steps only while at least 8 remain, so the count can never underflow.
    always_comb begin
        coarse_step    = COARSE_EN && (remaining >= 6'd8);
        step_code      = {dir_q, coarse_step};
        remaining_next = remaining - (coarse_step ? 6'd8 : 6'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= 6'd0;
            dir_q     <= 1'b0;
            sh_data   <= 64'd0;
            amount_q  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sh_data   <= req_data;
                        dir_q     <= req_dir;
                        remaining <= req_count;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (remaining != 6'd0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    remaining <= remaining_next;
                    amount_q  <= step_code;
                    if (remaining_next == 6'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The step code is live during SHIFT and otherwise holds the last issued step.
    assign req_ready = rst_n && (state == IDLE);
    assign sh_load   = (state == LOAD);
    assign sh_ena    = (state == SHIFT);
    assign sh_amount = (state == SHIFT) ? step_code : amount_q;
    assign rsp_valid = (state == DONE);
    assign rsp_data  = sh_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - checks coarse and fine-step sequencers against a shifter model and scoreboard
module tb_shift_sequencer;

    typedef struct {
        logic [63:0] data;
        logic        dir;
        logic [5:0]  cnt;
        logic [63:0] res;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_dir = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [63:0] req_data = 64'd0;
    logic [5:0]  req_count = 6'd0;

    logic        req_ready [2];
    logic        sh_load [2];
    logic        sh_ena [2];
    logic        rsp_valid [2];
    logic        busy [2];
    logic [1:0]  sh_amount [2];
    logic [63:0] sh_data [2];
    logic [63:0] rsp_data [2];
    logic [63:0] sh_q0, sh_q1;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc [2];
    int steps [2];
    bit seen [2];
    int rem [2];
    logic dir_m [2];
    exp_t q0 [$];
    exp_t q1 [$];
    vec_t vecs [9];

    always #5 clk = ~clk;

    shift_sequencer #(.COARSE_EN(1'b1)) dut_coarse (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_data(req_data), .req_dir(req_dir), .req_count(req_count),
        .sh_load(sh_load[0]), .sh_ena(sh_ena[0]), .sh_amount(sh_amount[0]),
        .sh_data(sh_data[0]), .sh_q(sh_q0), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]), .busy(busy[0])
    );

    shift_sequencer #(.COARSE_EN(1'b0)) dut_fine (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_data(req_data), .req_dir(req_dir), .req_count(req_count),
        .sh_load(sh_load[1]), .sh_ena(sh_ena[1]), .sh_amount(sh_amount[1]),
        .sh_data(sh_data[1]), .sh_q(sh_q1), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]), .busy(busy[1])
    );

    function automatic logic [63:0] step(input logic [63:0] q, input logic [1:0] a);
        logic signed [63:0] s;
        s = q;
        case (a)
            2'd0:    return q << 1;
            2'd1:    return q << 8;
            2'd2:    return s >>> 1;
            default: return s >>> 8;
        endcase
    endfunction

    // Behavioural shifter the sequencers drive.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q0 <= 64'd0;
        else if (sh_load[0]) sh_q0 <= sh_data[0];
        else if (sh_ena[0]) sh_q0 <= step(sh_q0, sh_amount[0]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q1 <= 64'd0;
        else if (sh_load[1]) sh_q1 <= sh_data[1];
        else if (sh_ena[1]) sh_q1 <= step(sh_q1, sh_amount[1]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b0;
        e.res = 64'd0;
        e.k = 0;
        if (i == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            ok = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            ok = 1'b1;
        end
    endtask

    // Cycle monitor: cycle index advances each falling edge; an accept cycle is index 0.
    initial begin
        exp_t e;
        bit   ok;
        bit   coarse;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                for (int i = 0; i < 2; i++) begin
                    seen[i] = 1'b1;
                    steps[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (sh_load[i] && sh_ena[i])
                        chk($sformatf("load_ena_overlap[%0d]", i), 64'd1, 64'd0);
                    if (req_ready[i] && rsp_valid[i])
                        chk($sformatf("ready_valid_overlap[%0d]", i), 64'd1, 64'd0);
                    if (sh_ena[i]) begin
                        steps[i]++;
                        coarse = (i == 0) && (rem[i] >= 8);
                        chk($sformatf("sh_amount[%0d]", i), 64'(sh_amount[i]), 64'({dir_m[i], coarse}));
                        rem[i] -= coarse ? 8 : 1;
                    end
                    if (rsp_valid[i] && !seen[i]) begin
                        seen[i] = 1'b1;
                        pop_exp(i, e, ok);
                        if (!ok) begin
                            chk($sformatf("unexpected_rsp[%0d]", i), 64'd1, 64'd0);
                        end else begin
                            chk($sformatf("rsp_data[%0d]", i), rsp_data[i], e.res);
                            chk($sformatf("steps[%0d]", i), 64'(steps[i]), 64'(e.k));
                            chk($sformatf("latency[%0d]", i), 64'(cyc - acc_cyc[i]), 64'(2 + e.k));
                        end
                    end
                    if (req_valid && req_ready[i]) begin
                        acc_cyc[i] = cyc;
                        steps[i] = 0;
                        seen[i] = 1'b0;
                        rem[i] = int'(req_count);
                        dir_m[i] = req_dir;
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [5:0] cnt, input logic [63:0] res);
        exp_t e;
        e.res = res;
        e.k = int'(cnt) / 8 + int'(cnt) % 8;
        q0.push_back(e);
        e.k = int'(cnt);
        q1.push_back(e);
    endtask

    task automatic drive_accept(input logic [63:0] data, input logic dir, input logic [5:0] cnt);
        int t;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_data = data;
        req_dir = dir;
        req_count = cnt;
        t = 0;
        @(negedge clk);
        while (!(req_ready[0] && req_ready[1]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data = {$urandom, $urandom};
        req_dir = 1'($urandom);
        req_count = 6'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy[0] || busy[1]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [63:0] data, input logic dir, input logic [5:0] cnt, input logic [63:0] res);
        push_exp(cnt, res);
        drive_accept(data, dir, cnt);
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_req_ready[%0d]", tag, i), 64'(req_ready[i]), 64'd0);
            chk($sformatf("%s_sh_load[%0d]", tag, i), 64'(sh_load[i]), 64'd0);
            chk($sformatf("%s_sh_ena[%0d]", tag, i), 64'(sh_ena[i]), 64'd0);
            chk($sformatf("%s_sh_amount[%0d]", tag, i), 64'(sh_amount[i]), 64'd0);
            chk($sformatf("%s_sh_data[%0d]", tag, i), sh_data[i], 64'd0);
            chk($sformatf("%s_rsp_valid[%0d]", tag, i), 64'(rsp_valid[i]), 64'd0);
            chk($sformatf("%s_busy[%0d]", tag, i), 64'(busy[i]), 64'd0);
        end
    endtask

    initial begin
        int t;
        vecs[0] = '{64'h0000_0000_0000_0001, 1'b0, 6'd9,  64'h0000_0000_0000_0200};
        vecs[1] = '{64'h8000_0000_0000_0000, 1'b1, 6'd4,  64'hF800_0000_0000_0000};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd63, 64'h8000_0000_0000_0000};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 6'd0,  64'h1234_5678_9ABC_DEF0};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 6'd8,  64'h0012_3456_789A_BCDE};
        vecs[5] = '{64'hF000_0000_0000_0000, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{64'h0000_0000_0000_00FF, 1'b0, 6'd16, 64'h0000_0000_00FF_0000};
        vecs[7] = '{64'h8000_0000_0000_0001, 1'b0, 6'd1,  64'h0000_0000_0000_0002};
        vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 6'd7,  64'h00FF_FFFF_FFFF_FFFF};

        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset[0]", 64'(req_ready[0]), 64'd1);
        chk("ready_after_reset[1]", 64'(req_ready[1]), 64'd1);

        for (int v = 0; v < 9; v++)
            run_op(vecs[v].data, vecs[v].dir, vecs[v].cnt, vecs[v].res);

        // Response back-pressure: a second request waits on the bus until the handshake.
        rsp_ready = 1'b0;
        push_exp(6'd3, 64'h0000_0000_0000_0528);
        push_exp(6'd2, 64'h0000_0000_0000_0040);
        drive_accept(64'h0000_0000_0000_00A5, 1'b0, 6'd3);
        req_valid = 1'b1;
        req_data = 64'h0000_0000_0000_0100;
        req_dir = 1'b1;
        req_count = 6'd2;
        t = 0;
        @(negedge clk);
        while (!rsp_valid[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("hold_timeout", 64'd1, 64'd0);
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("hold_rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd1);
                chk($sformatf("hold_rsp_data[%0d]", i), rsp_data[i], 64'h0000_0000_0000_0528);
                chk($sformatf("hold_req_ready[%0d]", i), 64'(req_ready[i]), 64'd0);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_handshake[0]", 64'(req_ready[0]), 64'd1);
        chk("ready_after_handshake[1]", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();

        // Reset mid-SHIFT of a count-20 request abandons it with no response.
        drive_accept(64'h0123_4567_89AB_CDEF, 1'b0, 6'd20);
        repeat (3) @(posedge clk);
        #2;
        chk("midshift_busy", 64'(sh_ena[0] && sh_ena[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset[0]", 64'(rsp_valid[0]), 64'd0);
        chk("no_rsp_after_reset[1]", 64'(rsp_valid[1]), 64'd0);
        run_op(64'h0123_4567_89AB_CDEF, 1'b0, 6'd20, 64'h5678_9ABC_DEF0_0000);

        chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter COARSE_EN, default 1, meaning that when 1, 8-bit steps are used for counts of 8 or more, and when 0, only 1-bit steps are used.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a shift request is presented.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port req_data, input, 64 bits: operand to shift.
REQ-007 The block SHALL have port req_dir, input, 1 bit: 0 = logical left, 1 = arithmetic right.
REQ-008 The block SHALL have port req_count, input, 6 bits: shift distance, 0..63.
REQ-009 The block SHALL have port sh_load, output, 1 bit: load strobe to the shifter.
REQ-010 The block SHALL have port sh_ena, output, 1 bit: shift-enable strobe to the shifter.
REQ-011 The block SHALL have port sh_amount, output, 2 bits: step code to the shifter (0 = left 1, 1 = left 8, 2 = arith right 1, 3 = arith right 8).
REQ-012 The block SHALL have port sh_data, output, 64 bits: load value to the shifter.
REQ-013 The block SHALL have port sh_q, input, 64 bits: the shifter's registered output.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-015 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-016 The block SHALL have port rsp_data, output, 64 bits: the shifted result.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, which latches req_data, req_dir and req_count and moves the FSM to LOAD.
REQ-020 In LOAD, for one cycle, the block SHALL drive sh_load=1 and sh_data equal to the latched operand; the next state SHALL be SHIFT if the count is nonzero, else DONE.
REQ-021 In SHIFT, sh_ena SHALL be 1 every cycle, and exactly one step SHALL be issued per cycle.
REQ-022 In SHIFT, if COARSE_EN=1 and the remaining count is 8 or more, sh_amount SHALL be 1 (left) or 3 (right) and the remaining count SHALL decrement by 8.
REQ-023 In SHIFT, in all other cases, sh_amount SHALL be 0 (left) or 2 (right) and the remaining count SHALL decrement by 1.
REQ-024 In SHIFT, when the step being issued brings the remaining count to 0, the next state SHALL be DONE.
REQ-025 The number of steps k SHALL equal floor(n/8) + (n mod 8) when COARSE_EN=1, and n when COARSE_EN=0.
REQ-026 In DONE, rsp_valid SHALL be 1 and rsp_data SHALL equal sh_q; the block SHALL hold DONE until rsp_valid and rsp_ready are both 1, then return to IDLE.
REQ-027 With rsp_ready held at 1, latency SHALL be as follows: rsp_valid first rises 2+k cycles after the accepting edge, and the next request may be accepted 1 cycle after the response handshake.
REQ-028 Outside LOAD, sh_load SHALL be 0; outside SHIFT, sh_ena SHALL be 0.
REQ-029 sh_amount and sh_data SHALL hold their last values when not strobed.
REQ-030 Request fields SHALL be ignored unless accepted in IDLE; changes to them during LOAD, SHIFT or DONE SHALL have no effect.
REQ-031 req_ready SHALL never be high while rsp_valid is high; requests and responses are never simultaneous.
REQ-032 sh_load and sh_ena SHALL never both be 1 in the same cycle.
REQ-033 The remaining-count register SHALL be 6 bits wide and SHALL never underflow; SHIFT is never entered with count 0.

Reset
REQ-034 While rst_n=0, the block SHALL immediately, regardless of clk, set the state to IDLE and drive req_ready=0, sh_load=0, sh_ena=0, sh_amount=0, sh_data=0, rsp_valid=0 and busy=0, and clear all latched request fields.
REQ-035 req_ready SHALL be 1 on the first rising edge after rst_n deasserts.
REQ-036 Reset asserted in any state SHALL abandon the operation with no response produced.

Verification
REQ-037 Scenario: COARSE_EN=1, left, data 0x0000_0000_0000_0001, count 9 -> steps: sh_amount 1 then 0; rsp_data 0x0000_0000_0000_0200; rsp_valid 4 cycles after accept.
REQ-038 Scenario: right, data 0x8000_0000_0000_0000, count 4 -> four steps of sh_amount=2; rsp_data 0xF800_0000_0000_0000.
REQ-039 Scenario: left, data 0xFFFF_FFFF_FFFF_FFFF, count 63, COARSE_EN=1 -> 14 steps (7x8 + 7x1); rsp_data 0x8000_0000_0000_0000; with COARSE_EN=0 -> 63 steps, same result.
REQ-040 Scenario: count 0, data 0x1234_5678_9ABC_DEF0 -> no sh_ena pulse; rsp_data 0x1234_5678_9ABC_DEF0, rsp_valid 2 cycles after accept.
REQ-041 Scenario: rsp_ready held at 0 for 5 cycles in DONE -> rsp_valid and rsp_data stable; req_ready=0; a new req_valid is not accepted until 1 cycle after the handshake.
REQ-042 Scenario: rst_n pulsed low mid-SHIFT of a count-20 request -> outputs reset values asynchronously; no rsp_valid; the next request completes correctly.
